// File: rtl/corr_accum.sv
// -----------------------------------------------------------------------------
// corr_accum -- per-channel early/prompt/late correlator and accumulator.
//
// Purpose:
//   Multiplies carrier-wiped I/Q baseband samples by the early, prompt and late
//   C/A chips (chip=1 -> +1, chip=0 -> -1) and integrates the six products
//   over one code period. On dump_enable the six sums move into host-readable
//   output registers and integration restarts from zero. A sample that arrives
//   on the dump edge belongs to the period being closed.
//
// Build option:
//   CORR_ACCUM_SAT_EN -- when defined, every accumulator add saturates and
//   sat_flag reports whether any add saturated in the last dumped period.
//   When undefined, adds wrap modulo 2^ACC_W and sat_flag is tied to 0.
//
// Ports:
//   clk           system clock
//   rstn          synchronous active-low reset
//   chan_clear    synchronous clear of accumulators, outputs and flags
//   sample_valid  i_sample/q_sample valid this cycle
//   i_sample      signed in-phase sample, SAMPLE_W bits
//   q_sample      signed quadrature sample, SAMPLE_W bits
//   early/prompt/late  C/A chips aligned with sample_valid
//   dump_enable   code-period boundary pulse
//   read_ack      host has read the dump registers
//   i_early..q_late  signed dumped sums, ACC_W bits each
//   acc_valid     a new dump is waiting to be read
//   missed_dump   sticky: a dump overwrote unread data
//   sat_flag      saturation occurred in the last dumped period
// -----------------------------------------------------------------------------
module corr_accum #(
  parameter int SAMPLE_W = 3,
  parameter int ACC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       chan_clear,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] q_sample,
  input  logic                       early,
  input  logic                       prompt,
  input  logic                       late,
  input  logic                       dump_enable,
  input  logic                       read_ack,
  output logic signed [ACC_W-1:0]    i_early,
  output logic signed [ACC_W-1:0]    q_early,
  output logic signed [ACC_W-1:0]    i_prompt,
  output logic signed [ACC_W-1:0]    q_prompt,
  output logic signed [ACC_W-1:0]    i_late,
  output logic signed [ACC_W-1:0]    q_late,
  output logic                       acc_valid,
  output logic                       missed_dump,
  output logic                       sat_flag
);

  // Accumulator slot order: i_early, q_early, i_prompt, q_prompt, i_late, q_late
  localparam int N_ACC = 6;

  // Sample times chip sign. The sample is widened by one bit before negation
  // so the most negative code (-2^(SAMPLE_W-1)) negates without overflow.
  function automatic logic signed [ACC_W-1:0] chip_product(
    input logic signed [SAMPLE_W-1:0] smp,
    input logic                       chip
  );
    logic signed [SAMPLE_W:0] ext_v;
    ext_v = {smp[SAMPLE_W-1], smp};
    if (chip) begin
      ext_v = ext_v;
    end else begin
      ext_v = -ext_v;
    end
    return {{(ACC_W-SAMPLE_W-1){ext_v[SAMPLE_W]}}, ext_v};
  endfunction

`ifdef CORR_ACCUM_SAT_EN
  // Saturating add. Returns {saturated, result}; overflow is detected from
  // disagreement between the two top bits of a one-bit-wider sum.
  function automatic logic [ACC_W:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] wide_v;
    logic [ACC_W:0] res_v;
    wide_v = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (wide_v[ACC_W] != wide_v[ACC_W-1]) begin
      if (wide_v[ACC_W]) begin
        res_v = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res_v = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      res_v = {1'b0, wide_v[ACC_W-1:0]};
    end
    return res_v;
  endfunction
`endif

  logic signed [ACC_W-1:0] prod_s [N_ACC];
  logic signed [ACC_W-1:0] sum_s  [N_ACC];
  logic signed [ACC_W-1:0] acc_r  [N_ACC];
  logic signed [ACC_W-1:0] out_r  [N_ACC];
  logic                    acc_valid_r;
  logic                    missed_dump_r;
  logic                    ack_s;

  // Only acknowledge when there is something to acknowledge.
  assign ack_s = read_ack & acc_valid_r;

  // Six chip products for the current sample.
  always_comb begin
    prod_s[0] = chip_product(i_sample, early);
    prod_s[1] = chip_product(q_sample, early);
    prod_s[2] = chip_product(i_sample, prompt);
    prod_s[3] = chip_product(q_sample, prompt);
    prod_s[4] = chip_product(i_sample, late);
    prod_s[5] = chip_product(q_sample, late);
  end

`ifdef CORR_ACCUM_SAT_EN
  logic [N_ACC-1:0] sat_hit_s;
  logic             any_sat_s;
  logic             sat_int_r;
  logic             sat_flag_r;

  // Next accumulator value with saturation; sat_hit_s marks clamped adds.
  always_comb begin
    for (int k = 0; k < N_ACC; k++) begin
      sum_s[k]     = acc_r[k];
      sat_hit_s[k] = 1'b0;
      if (sample_valid) begin
        {sat_hit_s[k], sum_s[k]} = sat_add(acc_r[k], prod_s[k]);
      end else begin
        sum_s[k]     = acc_r[k];
        sat_hit_s[k] = 1'b0;
      end
    end
  end

  assign any_sat_s = |sat_hit_s;

  // Per-period saturation tracker; a clamp on the dump edge counts for the
  // closing period, so it is folded into sat_flag rather than the new period.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sat_int_r  <= 1'b0;
      sat_flag_r <= 1'b0;
    end else if (chan_clear) begin
      sat_int_r  <= 1'b0;
      sat_flag_r <= 1'b0;
    end else if (dump_enable) begin
      sat_flag_r <= sat_int_r | any_sat_s;
      sat_int_r  <= 1'b0;
    end else begin
      sat_int_r  <= sat_int_r | any_sat_s;
    end
  end

  assign sat_flag = sat_flag_r;
`else
  // Next accumulator value, two's-complement wrap.
  always_comb begin
    for (int k = 0; k < N_ACC; k++) begin
      sum_s[k] = acc_r[k];
      if (sample_valid) begin
        sum_s[k] = acc_r[k] + prod_s[k];
      end else begin
        sum_s[k] = acc_r[k];
      end
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Working accumulators: restart at zero on dump, otherwise integrate.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < N_ACC; k++) acc_r[k] <= {ACC_W{1'b0}};
    end else if (chan_clear) begin
      for (int k = 0; k < N_ACC; k++) acc_r[k] <= {ACC_W{1'b0}};
    end else if (dump_enable) begin
      for (int k = 0; k < N_ACC; k++) acc_r[k] <= {ACC_W{1'b0}};
    end else if (sample_valid) begin
      for (int k = 0; k < N_ACC; k++) acc_r[k] <= sum_s[k];
    end
  end

  // Dump registers: capture the closing period including any same-edge sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < N_ACC; k++) out_r[k] <= {ACC_W{1'b0}};
    end else if (chan_clear) begin
      for (int k = 0; k < N_ACC; k++) out_r[k] <= {ACC_W{1'b0}};
    end else if (dump_enable) begin
      for (int k = 0; k < N_ACC; k++) out_r[k] <= sum_s[k];
    end
  end

  // Host handshake: a dump sets acc_valid even if acknowledged on the same
  // edge; missed_dump only sets when unread data is overwritten without ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_valid_r   <= 1'b0;
      missed_dump_r <= 1'b0;
    end else if (chan_clear) begin
      acc_valid_r   <= 1'b0;
      missed_dump_r <= 1'b0;
    end else begin
      if (dump_enable) begin
        acc_valid_r <= 1'b1;
      end else if (ack_s) begin
        acc_valid_r <= 1'b0;
      end
      if (dump_enable && acc_valid_r && !read_ack) begin
        missed_dump_r <= 1'b1;
      end else if (ack_s) begin
        missed_dump_r <= 1'b0;
      end
    end
  end

  assign i_early     = out_r[0];
  assign q_early     = out_r[1];
  assign i_prompt    = out_r[2];
  assign q_prompt    = out_r[3];
  assign i_late      = out_r[4];
  assign q_late      = out_r[5];
  assign acc_valid   = acc_valid_r;
  assign missed_dump = missed_dump_r;

endmodule

// File: tb/tb_corr_accum.sv
// -----------------------------------------------------------------------------
// tb_corr_accum -- self-checking bench for corr_accum (SAMPLE_W=3, ACC_W=16).
// A behavioural model predicts each dump; predictions are queued when the dump
// is driven and compared against the DUT outputs after that edge.
// -----------------------------------------------------------------------------
module tb_corr_accum;

  logic              clk = 1'b0;
  logic              rstn;
  logic              chan_clear;
  logic              sample_valid;
  logic signed [2:0] i_sample;
  logic signed [2:0] q_sample;
  logic              early, prompt, late;
  logic              dump_enable;
  logic              read_ack;
  logic signed [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
  logic              acc_valid, missed_dump, sat_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [95:0] sums;
    bit          sat;
  } exp_t;

  exp_t sb[$];
  int   m_acc[6];
  bit   m_sat;

  corr_accum #(.SAMPLE_W(3), .ACC_W(16)) dut (
    .clk(clk), .rstn(rstn), .chan_clear(chan_clear),
    .sample_valid(sample_valid), .i_sample(i_sample), .q_sample(q_sample),
    .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .read_ack(read_ack),
    .i_early(i_early), .q_early(q_early), .i_prompt(i_prompt),
    .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
    .acc_valid(acc_valid), .missed_dump(missed_dump), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic int prod(int s, bit c);
    return c ? s : -s;
  endfunction

  function automatic int m_add(int a, int b, output bit hit);
    int t;
    t   = a + b;
    hit = 1'b0;
`ifdef CORR_ACCUM_SAT_EN
    if (t > 32767) begin t = 32767; hit = 1'b1; end
    else if (t < -32768) begin t = -32768; hit = 1'b1; end
`else
    begin
      logic signed [15:0] w;
      w = t[15:0];
      t = w;
    end
`endif
    return t;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 6; k++) m_acc[k] = 0;
    m_sat = 1'b0;
  endtask

  // One clock of stimulus; updates the model and queues a prediction on dump.
  task automatic tick(input bit sv, input int iv, input int qv, input bit e,
                      input bit p, input bit l, input bit dmp, input bit ack);
    int pr[6];
    int nx[6];
    bit hit, h;
    exp_t ex;
    sample_valid = sv; i_sample = iv[2:0]; q_sample = qv[2:0];
    early = e; prompt = p; late = l; dump_enable = dmp; read_ack = ack;
    pr[0] = prod(iv, e); pr[1] = prod(qv, e); pr[2] = prod(iv, p);
    pr[3] = prod(qv, p); pr[4] = prod(iv, l); pr[5] = prod(qv, l);
    hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (sv) begin nx[k] = m_add(m_acc[k], pr[k], h); hit |= h; end
      else nx[k] = m_acc[k];
    end
    if (dmp) begin
      ex.sums = {nx[0][15:0], nx[1][15:0], nx[2][15:0],
                 nx[3][15:0], nx[4][15:0], nx[5][15:0]};
      ex.sat  = m_sat | hit;
      sb.push_back(ex);
      for (int k = 0; k < 6; k++) m_acc[k] = 0;
      m_sat = 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) m_acc[k] = nx[k];
      m_sat |= hit;
    end
    @(posedge clk); #1;
    sample_valid = 1'b0; dump_enable = 1'b0; read_ack = 1'b0;
  endtask

  task automatic test_reset();
    exp_t ex;
    // Build nonzero outputs and a half-integrated period.
    for (int n = 0; n < 4; n++) tick(1, 2, -3, 1, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums) begin
      errors++; $display("FAIL pre_reset_dump: got %h expected %h",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, ex.sums);
    end
    for (int n = 0; n < 3; n++) tick(1, 1, 1, 1, 1, 1, 0, 0);
    rstn = 1'b0; sample_valid = 1'b1; dump_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late, acc_valid, missed_dump, sat_flag}
        !== {96'd0, 3'b000}) begin
      errors++; $display("FAIL reset_state: got %h/%b%b%b expected 0/000",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, acc_valid, missed_dump, sat_flag);
    end
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1; sample_valid = 1'b0; dump_enable = 1'b0;
    model_clear();
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== 96'd0 ||
        ex.sums !== 96'd0) begin
      errors++; $display("FAIL post_reset_dump: got %h expected 0",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late});
    end
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_valid: got %b expected 1", acc_valid);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_basic();
    exp_t ex;
    for (int n = 0; n < 10; n++) tick(1, 3, -2, 1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums) begin
      errors++; $display("FAIL basic_scoreboard: got %h expected %h",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, ex.sums);
    end
    checks++;
    if (i_early !== 16'sd30 || q_early !== -16'sd20 || i_prompt !== 16'sd30 ||
        q_prompt !== -16'sd20 || i_late !== -16'sd30 || q_late !== 16'sd20) begin
      errors++; $display("FAIL basic_values: got %0d %0d %0d %0d %0d %0d expected 30 -20 30 -20 -30 20",
        i_early, q_early, i_prompt, q_prompt, i_late, q_late);
    end
    checks++;
    if (acc_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got %b expected 1", acc_valid);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (acc_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ack: got %b expected 0", acc_valid);
    end
  endtask

  task automatic test_dump_boundary();
    exp_t ex;
    for (int n = 0; n < 5; n++) tick(1, -4, 0, 1, 1, 0, 0, 0);
    tick(1, -4, 0, 1, 1, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums) begin
      errors++; $display("FAIL boundary_scoreboard: got %h expected %h",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, ex.sums);
    end
    checks++;
    if (i_late !== 16'sd24) begin
      errors++; $display("FAIL boundary_i_late: got %0d expected 24", i_late);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 0, 0, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if (i_late !== 16'sd2 || {i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums) begin
      errors++; $display("FAIL restart_i_late: got %0d expected 2", i_late);
    end
    tick(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_handshake();
    logic [1:0] seq_exp [6];
    bit dmp_seq [6];
    bit ack_seq [6];
    dmp_seq = '{1, 1, 0, 1, 1, 0};
    ack_seq = '{0, 0, 1, 0, 1, 1};
    seq_exp = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
    for (int n = 0; n < 6; n++) begin
      tick(0, 0, 0, 0, 0, 0, dmp_seq[n], ack_seq[n]);
      if (dmp_seq[n]) void'(sb.pop_front());
      checks++;
      if ({acc_valid, missed_dump} !== seq_exp[n]) begin
        errors++; $display("FAIL handshake_step%0d: got %b%b expected %b",
          n, acc_valid, missed_dump, seq_exp[n]);
      end
    end
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if ({acc_valid, missed_dump} !== 2'b00) begin
      errors++; $display("FAIL idle_ack: got %b%b expected 00", acc_valid, missed_dump);
    end
  endtask

  task automatic test_overflow();
    exp_t ex;
    for (int n = 0; n < 11000; n++) tick(1, 3, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums ||
        sat_flag !== ex.sat) begin
      errors++; $display("FAIL overflow_scoreboard: got %h/%b expected %h/%b",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, sat_flag, ex.sums, ex.sat);
    end
`ifdef CORR_ACCUM_SAT_EN
    checks++;
    if (i_prompt !== 16'sd32767 || sat_flag !== 1'b1) begin
      errors++; $display("FAIL overflow_sat: got %0d/%b expected 32767/1", i_prompt, sat_flag);
    end
`else
    checks++;
    if (i_prompt !== -16'sd32536 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL overflow_wrap: got %0d/%b expected -32536/0", i_prompt, sat_flag);
    end
`endif
    for (int n = 0; n < 3; n++) tick(1, 1, 0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if (sat_flag !== 1'b0 || i_prompt !== 16'sd3 || ex.sat !== 1'b0) begin
      errors++; $display("FAIL clean_period: got %0d/%b expected 3/0", i_prompt, sat_flag);
    end
  endtask

  task automatic test_chan_clear();
    exp_t ex;
    for (int n = 0; n < 20; n++) tick(1, 1, 0, 1, 0, 0, 0, 0);
    chan_clear = 1'b1;
    @(posedge clk); #1;
    chan_clear = 1'b0;
    model_clear();
    checks++;
    if ({i_early, q_early, i_prompt, q_prompt, i_late, q_late, acc_valid, missed_dump, sat_flag}
        !== {96'd0, 3'b000}) begin
      errors++; $display("FAIL clear_state: got %h/%b%b%b expected 0/000",
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late}, acc_valid, missed_dump, sat_flag);
    end
    for (int n = 0; n < 4; n++) tick(1, 1, 0, 1, 0, 0, 0, 0);
    checks++;
    if (i_early !== 16'sd0) begin
      errors++; $display("FAIL clear_hold: got %0d expected 0", i_early);
    end
    tick(0, 0, 0, 0, 0, 0, 1, 0);
    ex = sb.pop_front();
    checks++;
    if (i_early !== 16'sd4 || missed_dump !== 1'b0 ||
        {i_early, q_early, i_prompt, q_prompt, i_late, q_late} !== ex.sums) begin
      errors++; $display("FAIL clear_dump: got %0d/%b expected 4/0", i_early, missed_dump);
    end
  endtask

  initial begin
    rstn = 1'b0; chan_clear = 1'b0; sample_valid = 1'b0; dump_enable = 1'b0;
    read_ack = 1'b0; i_sample = 3'sd0; q_sample = 3'sd0;
    early = 1'b0; prompt = 1'b0; late = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    test_reset();
    test_basic();
    test_dump_boundary();
    test_handshake();
    test_overflow();
    test_chan_clear();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_accum.md
Name: corr_accum

Overview:
- Per-channel correlator/accumulator sitting directly downstream of the C/A code generator.
- Takes carrier-wiped baseband I/Q samples and multiplies each by the early, prompt and late code chips. Accumulates the six products over one code period.
- On the code generator's dump_enable pulse, transfers the six sums into host-readable output registers and restarts integration.
- Provides a data-ready / missed-dump handshake for the tracking-loop software.

Parameters:
SAMPLE_W, 3, width of signed two's-complement I/Q baseband samples (range -2^(SAMPLE_W-1) .. 2^(SAMPLE_W-1)-1)
ACC_W, 16, width of each signed accumulator and output register

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
chan_clear  input  1  synchronous clear of all accumulators, outputs and flags (host write & chip select to channel setup)
sample_valid  input  1  one-cycle strobe: i_sample/q_sample valid this cycle
i_sample  input  SAMPLE_W  signed in-phase baseband sample
q_sample  input  SAMPLE_W  signed quadrature baseband sample
early  input  1  early C/A chip
prompt  input  1  prompt C/A chip
late  input  1  late C/A chip
dump_enable  input  1  one-cycle pulse marking code-period boundary
read_ack  input  1  one-cycle pulse: host has read the dump registers
i_early, q_early, i_prompt, q_prompt, i_late, q_late  output  ACC_W each  signed dumped sums
acc_valid  output  1  new dump available
missed_dump  output  1  sticky: a dump overwrote unread data
sat_flag  output  1  saturation occurred in the last dumped period (see Optional Feature)

Behaviour:
- Reset is synchronous and active-low on clk. While rstn=0: all six working accumulators = 0, all six outputs = 0, acc_valid = 0, missed_dump = 0, sat_flag = 0, internal sat tracking = 0.
- Priority: rstn > chan_clear > dump_enable > sample accumulation. chan_clear=1 gives the same result as reset.
- Chip mapping: chip=1 → multiply by +1; chip=0 → multiply by -1.
- Negation is done at SAMPLE_W+1 bits, so -2^(SAMPLE_W-1) negates exactly. The product is sign-extended to ACC_W.
- Accumulation: on each edge with sample_valid=1, each working accumulator adds its product (I/Q × E/P/L). This gives six independent adders, with no pipelining inside.
- Dump: on an edge with dump_enable=1:
  - Each output loads working + concurrent product if sample_valid=1, otherwise working.
  - Working accumulators load 0, so the concurrent sample belongs to the closing period.
  - Outputs are stable from that edge until the next dump, chan_clear or reset.
- Latency: a sample presented at edge n is visible in the outputs at the first dump edge ≥ n.
- acc_valid:
  - Set on the dump edge.
  - Cleared on a read_ack edge.
  - If dump and read_ack coincide, acc_valid = 1 (set wins).
- missed_dump:
  - Set on a dump edge when acc_valid=1 and read_ack=0.
  - Cleared by read_ack, except when a dump on the same edge sets it.
  - Dump with acc_valid=1 and read_ack=1 on the same edge does not set it.
- read_ack with acc_valid=0: no effect.
- Accumulator overflow (default build): two's-complement wrap modulo 2^ACC_W. sat_flag is tied 0.
- Inputs early/prompt/late are sampled the same cycle as sample_valid; no internal alignment delay.

Optional Feature:
- Macro: CORR_ACCUM_SAT_EN.
- Defined:
  - Each working-accumulator add saturates to +(2^(ACC_W-1)-1) / -2^(ACC_W-1).
  - Any saturation sets an internal per-period flag. It is also set if the product added on the dump edge itself saturates.
  - On the dump edge, sat_flag loads the internal flag and the internal flag clears.
- Not defined: wrap arithmetic, sat_flag constant 0, no saturation logic synthesized.

Test Plan:
1. rstn=0 for 3 cycles mid-integration with nonzero outputs → all outputs, acc_valid, missed_dump, sat_flag = 0 on the first edge with rstn=0; after release, a dump with no samples gives all outputs 0 and acc_valid=1.
2. 10 samples, i=+3, q=-2, early=1, prompt=1, late=0, then dump → i_early=i_prompt=30, q_early=q_prompt=-20, i_late=-30, q_late=20, acc_valid=1; read_ack → acc_valid=0.
3. 5 samples i=-4 (late=0), plus a 6th sample i=-4 on the dump_enable cycle → i_late=+24; the next period with 2 samples i=+1, late=1 dumps i_late=2, proving the working accumulator restarted at 0.
4. Two dumps with no read_ack → missed_dump=1, acc_valid=1; read_ack alone → both 0; dump coincident with read_ack → acc_valid=1, missed_dump=0.
5. 11000 samples i=+3, prompt=1, then dump → default build i_prompt = -32536 (wrap), sat_flag=0; with CORR_ACCUM_SAT_EN i_prompt=32767, sat_flag=1, next clean period dumps sat_flag=0.
6. 20 samples i=+1 early=1, chan_clear, 4 samples i=+1, dump → i_early=4, missed_dump=0, outputs before the dump = 0.
